hmac_arbiter: RTL and testbench
===============================

Name: hmac_arbiter

Overview:
- Round-robin arbiter that shares one HMAC engine between NUM_REQ requesters, e.g. the DRAM write-tag generator and the read-tag verifier.
- Sits between the requesters and the engine's request/response ports.
- One transaction is in flight at a time, because the engine is non-pipelined.
- Routes the 128-bit tag back to the requester that issued the request.

Parameters:
DATA_WIDTH, 512, width of the data block to authenticate
ADDR_WIDTH, 32, width of the address bound into the MAC
COUNTER_WIDTH, 32, width of the freshness counter bound into the MAC
NUM_REQ, 2, number of requesters (2..8)
ID_WIDTH, $clog2(NUM_REQ) (minimum 1), width of the grant index

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
req_data  in  NUM_REQ*DATA_WIDTH  packed per-requester data; requester i occupies slice [i*DATA_WIDTH +: DATA_WIDTH]
req_addr  in  NUM_REQ*ADDR_WIDTH  packed per-requester address
req_counter  in  NUM_REQ*COUNTER_WIDTH  packed per-requester counter
req_val  in  NUM_REQ  per-requester request valid
req_rdy  out  NUM_REQ  per-requester request ready
rsp_hmac  out  128  tag; broadcast to all requesters, qualified by rsp_val
rsp_val  out  NUM_REQ  per-requester response valid
rsp_rdy  in  NUM_REQ  per-requester response ready
eng_req_data  out  DATA_WIDTH  engine data
eng_req_addr  out  ADDR_WIDTH  engine address
eng_req_counter  out  COUNTER_WIDTH  engine counter
eng_req_val  out  1  engine request valid
eng_req_rdy  in  1  engine request ready
eng_hmac  in  128  engine tag
eng_hmac_val  in  1  engine tag valid
eng_hmac_rdy  out  1  engine tag ready
busy  out  1  high whenever the state is not IDLE
grant_id  out  ID_WIDTH  currently granted requester; value is held in IDLE

Behaviour:
- Registered state: state_r in {IDLE, ISSUE, WAIT_RSP}; rr_ptr_r (ID_WIDTH); grant_r (ID_WIDTH).
- Reset: state_r=IDLE, rr_ptr_r=0, grant_r=0. Hence req_rdy=0, rsp_val=0, eng_req_val=0, eng_hmac_rdy=0, busy=0, grant_id=0.
- IDLE:
  - If any req_val bit is set, grant_r <= first index i with req_val[i]=1, searching rr_ptr_r, rr_ptr_r+1, ... modulo NUM_REQ (wrap-around).
  - Then go to ISSUE.
  - No handshakes complete in IDLE.
- ISSUE:
  - eng_req_* = slice grant_r of the req_* buses.
  - eng_req_val = req_val[grant_r].
  - req_rdy[grant_r] = eng_req_rdy; all other req_rdy bits are 0.
  - On req_val[grant_r] && eng_req_rdy: rr_ptr_r <= (grant_r+1) mod NUM_REQ, then go to WAIT_RSP.
  - If req_val[grant_r] drops before the handshake: return to IDLE, rr_ptr_r unchanged. This is a protocol violation by the requester but must not hang the arbiter.
- WAIT_RSP:
  - rsp_hmac = eng_hmac.
  - rsp_val[grant_r] = eng_hmac_val; other rsp_val bits are 0.
  - eng_hmac_rdy = rsp_rdy[grant_r].
  - On eng_hmac_val && rsp_rdy[grant_r]: go to IDLE.
- Datapath: fully combinational between requester and engine; no data registers. The engine captures the request inputs itself.
- Latency:
  - Request val to engine val: 1 cycle (the IDLE arbitration cycle).
  - Engine tag to requester: 0 cycles.
  - Minimum gap between consecutive grants: one IDLE cycle.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NUM_REQ-1,0,...
- Other requesters see req_rdy=0 for the whole transaction; the arbiter never buffers a second request.
- A new request arriving while busy is held off and arbitrated on the next IDLE cycle.
- Response backpressure (rsp_rdy=0) stalls in WAIT_RSP indefinitely; the engine must hold its tag.
- Reset mid-operation: returns to IDLE immediately. The engine shares rst_n, so no stale tag is delivered after reset.
- NUM_REQ=1: rr_ptr_r stays 0; behaves as a single-requester pass-through plus the one-cycle IDLE.

Optional Feature:
Macro HMAC_ARB_STRICT_PRIO_EN.
- Defined: fixed priority; IDLE grants the lowest-index valid requester; rr_ptr_r is held at 0 and ignored.
- Undefined: round-robin exactly as specified under Behaviour.
- All ports and handshakes are identical in both builds.

Test Plan:
- Reset, then req_val=2'b01 with data=0xAB..., addr=0x1000, counter=5 -> eng_req_val rises one cycle later carrying those values; req_rdy=2'b01 only while eng_req_rdy=1; after the engine returns tag T, rsp_val=2'b01 and rsp_hmac=T.
- Both requesters valid continuously for 4 transactions -> grant_id sequence 0,1,0,1. With HMAC_ARB_STRICT_PRIO_EN defined -> 0,0,0,0.
- Hold rsp_rdy[1]=0 for 10 cycles during requester 1's transaction -> eng_hmac_rdy=0 and the state stays WAIT_RSP; requester 0's req_rdy stays 0; completion occurs on the first cycle rsp_rdy[1]=1.
- Requester 1 granted, then drops req_val while eng_req_rdy=0 -> returns to IDLE, no engine handshake, rr_ptr_r unchanged; next grant goes to requester 1 if it reasserts.
- Assert rst_n=0 for 1 cycle while in WAIT_RSP -> next cycle busy=0, all rsp_val=0, grant_id=0; a following request completes normally.
- NUM_REQ=3, rr_ptr_r=2, req_val=3'b011 -> grant 0 (wrap-around), after which rr_ptr_r=1.

Source files
------------

// File: rtl/hmac_arbiter.sv
// hmac_arbiter: shares one non-pipelined HMAC engine between NUM_REQ
// requesters. One transaction is in flight at a time. The request datapath
// and the returned tag are purely combinational, and the tag is routed back
// to the requester that issued the request.
//
// Ports
//   clk, rst_n                       clock, synchronous active-low reset
//   req_data/addr/counter            packed per-requester request fields
//   req_val / req_rdy                per-requester request handshake
//   rsp_hmac                         tag broadcast to all requesters
//   rsp_val / rsp_rdy                per-requester response handshake
//   eng_req_data/addr/counter        request fields of the granted requester
//   eng_req_val / eng_req_rdy        engine request handshake
//   eng_hmac, eng_hmac_val/rdy       engine tag handshake
//   busy                             high whenever the FSM is not IDLE
//   grant_id                         granted requester, held while IDLE
//
// Build option
//   HMAC_ARB_STRICT_PRIO_EN  defined: IDLE grants the lowest-index valid
//                            requester and the round-robin pointer stays 0.
//                            Undefined: round-robin arbitration.
module hmac_arbiter #(
   parameter int DATA_WIDTH    = 512,
   parameter int ADDR_WIDTH    = 32,
   parameter int COUNTER_WIDTH = 32,
   parameter int NUM_REQ       = 2,
   parameter int ID_WIDTH      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
   input  logic [NUM_REQ*COUNTER_WIDTH-1:0] req_counter,
   input  logic [NUM_REQ-1:0]               req_val,
   output logic [NUM_REQ-1:0]               req_rdy,
   output logic [127:0]                     rsp_hmac,
   output logic [NUM_REQ-1:0]               rsp_val,
   input  logic [NUM_REQ-1:0]               rsp_rdy,
   output logic [DATA_WIDTH-1:0]            eng_req_data,
   output logic [ADDR_WIDTH-1:0]            eng_req_addr,
   output logic [COUNTER_WIDTH-1:0]         eng_req_counter,
   output logic                             eng_req_val,
   input  logic                             eng_req_rdy,
   input  logic [127:0]                     eng_hmac,
   input  logic                             eng_hmac_val,
   output logic                             eng_hmac_rdy,
   output logic                             busy,
   output logic [ID_WIDTH-1:0]              grant_id
);

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_ISSUE    = 2'd1;
   localparam logic [1:0] ST_WAIT_RSP = 2'd2;

   logic [1:0]          state_q, state_d;
   logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
   logic [ID_WIDTH-1:0] grant_q, grant_d;

   logic [NUM_REQ-1:0]  grant_oh;
   logic                sel_val;
   logic                sel_rsp_rdy;
   logic [ID_WIDTH-1:0] arb_sel;
   logic                arb_found;
   logic [ID_WIDTH-1:0] rr_next;

   always_comb begin : grant_decode
      grant_oh = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         grant_oh[i] = (grant_q == ID_WIDTH'(i));
      end
   end

   assign sel_val     = |(req_val & grant_oh);
   assign sel_rsp_rdy = |(rsp_rdy & grant_oh);
   assign rr_next     = (grant_q == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_q + ID_WIDTH'(1);

   // Round-robin search as two linear passes: first the indices at or above
   // the pointer, then from 0 upward, which yields the wrap-around order
   // rr_ptr, rr_ptr+1, ..., NUM_REQ-1, 0, ... without a modulo index.
   always_comb begin : arbitrate
      arb_sel   = '0;
      arb_found = 1'b0;
`ifndef HMAC_ARB_STRICT_PRIO_EN
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (!arb_found && req_val[i] && (ID_WIDTH'(i) >= rr_ptr_q)) begin
            arb_sel   = ID_WIDTH'(i);
            arb_found = 1'b1;
         end
      end
`endif
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (!arb_found && req_val[i]) begin
            arb_sel   = ID_WIDTH'(i);
            arb_found = 1'b1;
         end
      end
   end

   always_comb begin : req_mux
      eng_req_data    = '0;
      eng_req_addr    = '0;
      eng_req_counter = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (grant_oh[i]) begin
            eng_req_data    = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            eng_req_addr    = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            eng_req_counter = req_counter[i*COUNTER_WIDTH +: COUNTER_WIDTH];
         end
      end
   end

   always_comb begin : fsm
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      grant_d      = grant_q;
      req_rdy      = '0;
      rsp_val      = '0;
      eng_req_val  = 1'b0;
      eng_hmac_rdy = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (|req_val) begin
               grant_d = arb_sel;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            eng_req_val = sel_val;
            req_rdy     = grant_oh & {NUM_REQ{eng_req_rdy}};
            // A requester withdrawing before the handshake is a protocol
            // violation; fall back to IDLE rather than wait for it.
            if (!sel_val) begin
               state_d = ST_IDLE;
            end else if (eng_req_rdy) begin
`ifndef HMAC_ARB_STRICT_PRIO_EN
               rr_ptr_d = rr_next;
`endif
               state_d  = ST_WAIT_RSP;
            end
         end
         ST_WAIT_RSP: begin
            rsp_val      = grant_oh & {NUM_REQ{eng_hmac_val}};
            eng_hmac_rdy = sel_rsp_rdy;
            if (eng_hmac_val && sel_rsp_rdy) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign rsp_hmac = eng_hmac;
   assign busy     = (state_q != ST_IDLE);
   assign grant_id = grant_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         rr_ptr_q <= '0;
         grant_q  <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         grant_q  <= grant_d;
      end
   end

endmodule

// File: tb/tb_hmac_arbiter.sv
// Testbench for hmac_arbiter: a 2-requester instance driven by a requester
// model and a small engine model, plus a 3-requester instance for the
// round-robin wrap-around case. Expected tags are queued when a request
// handshake completes and compared when the response handshake completes.
module tb_hmac_arbiter;

   localparam int DW  = 512;
   localparam int AW  = 32;
   localparam int CW  = 32;
   localparam int NR  = 2;
   localparam int IW  = 1;
   localparam int NR3 = 3;
   localparam int IW3 = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   // ---------------- main 2-requester instance ----------------
   logic [DW-1:0]      data_r [NR];
   logic [AW-1:0]      addr_r [NR];
   logic [CW-1:0]      cnt_r  [NR];
   logic [NR*DW-1:0]   req_data;
   logic [NR*AW-1:0]   req_addr;
   logic [NR*CW-1:0]   req_counter;
   logic [NR-1:0]      req_val, req_rdy, rsp_val, rsp_rdy;
   logic [127:0]       rsp_hmac;
   logic [DW-1:0]      eng_req_data;
   logic [AW-1:0]      eng_req_addr;
   logic [CW-1:0]      eng_req_counter;
   logic               eng_req_val, eng_req_rdy;
   logic [127:0]       eng_hmac;
   logic               eng_hmac_val, eng_hmac_rdy;
   logic               busy;
   logic [IW-1:0]      grant_id;

   always_comb begin
      req_data    = '0;
      req_addr    = '0;
      req_counter = '0;
      for (int i = 0; i < NR; i++) begin
         req_data[i*DW +: DW]    = data_r[i];
         req_addr[i*AW +: AW]    = addr_r[i];
         req_counter[i*CW +: CW] = cnt_r[i];
      end
   end

   hmac_arbiter #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .COUNTER_WIDTH(CW), .NUM_REQ(NR), .ID_WIDTH(IW)
   ) u_dut (
      .clk(clk), .rst_n(rst_n),
      .req_data(req_data), .req_addr(req_addr), .req_counter(req_counter),
      .req_val(req_val), .req_rdy(req_rdy),
      .rsp_hmac(rsp_hmac), .rsp_val(rsp_val), .rsp_rdy(rsp_rdy),
      .eng_req_data(eng_req_data), .eng_req_addr(eng_req_addr),
      .eng_req_counter(eng_req_counter), .eng_req_val(eng_req_val),
      .eng_req_rdy(eng_req_rdy), .eng_hmac(eng_hmac),
      .eng_hmac_val(eng_hmac_val), .eng_hmac_rdy(eng_hmac_rdy),
      .busy(busy), .grant_id(grant_id)
   );

   // ---------------- 3-requester instance ----------------
   logic [NR3*DW-1:0]  req_data3;
   logic [NR3*AW-1:0]  req_addr3;
   logic [NR3*CW-1:0]  req_counter3;
   logic [NR3-1:0]     rv3, rdy3, rspv3, rsp_rdy3;
   logic [127:0]       rsp_hmac3, eng_hmac3;
   logic [DW-1:0]      eng_req_data3;
   logic [AW-1:0]      eng_req_addr3;
   logic [CW-1:0]      eng_req_counter3;
   logic               eng_req_val3, eng_req_rdy3, eng_hmac_val3, eng_hmac_rdy3;
   logic               busy3;
   logic [IW3-1:0]     grant3;

   hmac_arbiter #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .COUNTER_WIDTH(CW), .NUM_REQ(NR3), .ID_WIDTH(IW3)
   ) u_dut3 (
      .clk(clk), .rst_n(rst_n),
      .req_data(req_data3), .req_addr(req_addr3), .req_counter(req_counter3),
      .req_val(rv3), .req_rdy(rdy3),
      .rsp_hmac(rsp_hmac3), .rsp_val(rspv3), .rsp_rdy(rsp_rdy3),
      .eng_req_data(eng_req_data3), .eng_req_addr(eng_req_addr3),
      .eng_req_counter(eng_req_counter3), .eng_req_val(eng_req_val3),
      .eng_req_rdy(eng_req_rdy3), .eng_hmac(eng_hmac3),
      .eng_hmac_val(eng_hmac_val3), .eng_hmac_rdy(eng_hmac_rdy3),
      .busy(busy3), .grant_id(grant3)
   );

   // ---------------- bench state ----------------
   typedef struct { int id; logic [127:0] tag; } sb_t;
   typedef struct { int n0; int n1; int ng; logic [3:0] gseq; } row_t;

   sb_t         sbq [$];
   int          glog [$];
   int unsigned want [NR];
   logic        eng_hold;
   logic        eng_pending;
   int          eng_lat;
   logic [127:0] eng_tag_r, eng_cap_tag;
   logic [NR-1:0] req_hs_f;
   logic        eng_hs_f, eng_rsp_hs_f, rst_f;
   int          errors = 0;
   int          checks = 0;

   function automatic logic [127:0] tag_of(logic [DW-1:0] d, logic [AW-1:0] a, logic [CW-1:0] c);
      logic [127:0] t;
      t = d[127:0] ^ d[255:128] ^ d[383:256] ^ d[511:384];
      t = t ^ {a, c, ~a, c + 32'h9e37_79b9};
      return t;
   endfunction

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive_req();
      for (int i = 0; i < NR; i++) req_val[i] = (want[i] != 0);
   endtask

   task automatic drive_eng();
      eng_req_rdy  = !eng_pending && !eng_hold;
      eng_hmac_val = eng_pending && (eng_lat == 0);
      eng_hmac     = eng_pending ? eng_tag_r : '0;
   endtask

   // Observe handshakes that will complete at the coming edge.
   task automatic monitor();
      logic [NR-1:0] rsp_hs;
      sb_t e;
      rst_f        = !rst_n;
      req_hs_f     = '0;
      eng_hs_f     = 1'b0;
      eng_rsp_hs_f = 1'b0;
      if (rst_n) begin
         req_hs_f     = req_val & req_rdy;
         eng_hs_f     = eng_req_val && eng_req_rdy;
         eng_rsp_hs_f = eng_hmac_val && eng_hmac_rdy;
         rsp_hs       = rsp_val & rsp_rdy;
         if (|req_hs_f || eng_hs_f) chk("req_eng_handshake", eng_hs_f, |req_hs_f);
         for (int i = 0; i < NR; i++)
            if (req_hs_f[i]) sbq.push_back('{i, tag_of(data_r[i], addr_r[i], cnt_r[i])});
         if (eng_hs_f) begin
            eng_cap_tag = tag_of(eng_req_data, eng_req_addr, eng_req_counter);
            glog.push_back(int'(grant_id));
         end
         if (|rsp_hs || eng_rsp_hs_f) chk("rsp_eng_handshake", |rsp_hs, eng_rsp_hs_f);
         for (int i = 0; i < NR; i++) begin
            if (rsp_hs[i]) begin
               if (sbq.size() == 0) begin
                  chk("sb_underflow", 1'b1, 1'b0);
               end else begin
                  e = sbq.pop_front();
                  chk("rsp_id", i, e.id);
                  chk("rsp_hmac", rsp_hmac, e.tag);
               end
            end
         end
      end
   endtask

   task automatic update();
      if (rst_f) begin
         eng_pending = 1'b0;
         sbq.delete();
      end else begin
         if (eng_rsp_hs_f) eng_pending = 1'b0;
         else if (eng_pending && eng_lat > 0) eng_lat--;
         if (eng_hs_f) begin
            eng_pending = 1'b1;
            eng_lat     = 2;
            eng_tag_r   = eng_cap_tag;
         end
         for (int i = 0; i < NR; i++) begin
            if (req_hs_f[i]) begin
               want[i]--;
               cnt_r[i]  = cnt_r[i] + 32'd1;
               addr_r[i] = addr_r[i] + 32'h40;
               data_r[i] = {data_r[i][DW-9:0], data_r[i][DW-1:DW-8]};
               data_r[i][31:0] = data_r[i][31:0] ^ cnt_r[i];
            end
         end
      end
      drive_req();
      drive_eng();
   endtask

   task automatic step();
      #1;
      monitor();
      @(posedge clk);
      #1;
      update();
   endtask

   function automatic logic all_idle();
      return (want[0] == 0) && (want[1] == 0) && (sbq.size() == 0) && !busy && !eng_pending;
   endfunction

   task automatic wait_idle(input string name, input int max);
      int n = 0;
      while (!all_idle() && n < max) begin
         step();
         n++;
      end
      chk(name, all_idle(), 1'b1);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      row_t        rows [7];
      logic [DW-1:0] exp_data;
      int          n;

`ifdef HMAC_ARB_STRICT_PRIO_EN
      rows[0] = '{1, 0, 1, 4'b0000};
      rows[1] = '{0, 1, 1, 4'b0001};
      rows[2] = '{2, 2, 4, 4'b1100};
      rows[3] = '{1, 1, 2, 4'b0010};
      rows[4] = '{0, 2, 2, 4'b0011};
      rows[5] = '{3, 1, 4, 4'b1000};
      rows[6] = '{1, 0, 1, 4'b0000};
`else
      rows[0] = '{1, 0, 1, 4'b0000};
      rows[1] = '{0, 1, 1, 4'b0001};
      rows[2] = '{2, 2, 4, 4'b1010};
      rows[3] = '{1, 1, 2, 4'b0010};
      rows[4] = '{0, 2, 2, 4'b0011};
      rows[5] = '{3, 1, 4, 4'b0010};
      rows[6] = '{1, 0, 1, 4'b0000};
`endif

      exp_data  = {64{8'hAB}};
      data_r[0] = {64{8'hAB}};
      addr_r[0] = 32'h1000;
      cnt_r[0]  = 32'd5;
      data_r[1] = {16{32'h0123_4567}};
      addr_r[1] = 32'h2000;
      cnt_r[1]  = 32'd9;
      want[0] = 0; want[1] = 0;
      eng_hold = 1'b0; eng_pending = 1'b0; eng_lat = 0; eng_tag_r = '0; eng_cap_tag = '0;
      req_hs_f = '0; eng_hs_f = 1'b0; eng_rsp_hs_f = 1'b0; rst_f = 1'b0;
      rsp_rdy = '1;
      req_data3 = {3{{16{32'h5a5a_0f0f}}}};
      req_addr3 = {32'h300, 32'h200, 32'h100};
      req_counter3 = {32'd3, 32'd2, 32'd1};
      rv3 = '0; rsp_rdy3 = '1; eng_req_rdy3 = 1'b1; eng_hmac_val3 = 1'b1;
      eng_hmac3 = 128'hC0FF_EE00_1122_3344_5566_7788_99AA_BBCC;
      drive_req();
      drive_eng();

      // Reset
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      #1;
      chk("rst_req_rdy", req_rdy, 2'b00);
      chk("rst_rsp_val", rsp_val, 2'b00);
      chk("rst_eng_req_val", eng_req_val, 1'b0);
      chk("rst_eng_hmac_rdy", eng_hmac_rdy, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_grant_id", grant_id, 1'b0);

      // Single transaction from requester 0
      want[0] = 1; eng_hold = 1'b1;
      drive_req(); drive_eng();
      #1;
      chk("t1_idle_eng_val", eng_req_val, 1'b0);
      chk("t1_idle_req_rdy", req_rdy, 2'b00);
      step();
      #1;
      chk("t1_eng_val", eng_req_val, 1'b1);
      chk("t1_eng_data", eng_req_data, exp_data);
      chk("t1_eng_addr", eng_req_addr, 32'h1000);
      chk("t1_eng_counter", eng_req_counter, 32'd5);
      chk("t1_rdy_blocked", req_rdy, 2'b00);
      chk("t1_busy", busy, 1'b1);
      eng_hold = 1'b0;
      drive_eng();
      #1;
      chk("t1_rdy", req_rdy, 2'b01);
      step();
      #1;
      n = 0;
      while (rsp_val == 2'b00 && n < 10) begin
         step();
         #1;
         n++;
      end
      chk("t1_rsp_val", rsp_val, 2'b01);
      chk("t1_rsp_hmac", rsp_hmac, tag_of(exp_data, 32'h1000, 32'd5));
      step();
      #1;
      chk("t1_done_idle", busy, 1'b0);

      // Table of multi-transaction patterns and expected grant order
      for (int r = 0; r < 7; r++) begin
         glog.delete();
         want[0] = rows[r].n0;
         want[1] = rows[r].n1;
         drive_req();
         wait_idle($sformatf("row%0d_drain", r), 200);
         chk($sformatf("row%0d_ngrants", r), glog.size(), rows[r].ng);
         for (int k = 0; k < rows[r].ng; k++)
            if (k < glog.size())
               chk($sformatf("row%0d_grant%0d", r, k), glog[k], rows[r].gseq[k]);
      end

      // Response backpressure on requester 1
      rsp_rdy = 2'b01;
      want[1] = 1;
      drive_req();
      #1;
      n = 0;
      while (!rsp_val[1] && n < 20) begin
         step();
         #1;
         n++;
      end
      chk("bp_rsp_seen", rsp_val, 2'b10);
      want[0] = 1;
      drive_req();
      for (int c = 0; c < 10; c++) begin
         #1;
         chk("bp_eng_hmac_rdy", eng_hmac_rdy, 1'b0);
         chk("bp_req_rdy", req_rdy, 2'b00);
         chk("bp_rsp_val", rsp_val, 2'b10);
         chk("bp_grant", grant_id, 1'b1);
         step();
      end
      rsp_rdy = 2'b11;
      #1;
      chk("bp_release", eng_hmac_rdy, 1'b1);
      step();
      #1;
      chk("bp_idle", busy, 1'b0);
      wait_idle("bp_drain", 50);

      // Requester 1 withdraws before the engine accepts
      glog.delete();
      eng_hold = 1'b1;
      want[1] = 1;
      drive_req(); drive_eng();
      step();
      #1;
      chk("pd_grant", grant_id, 1'b1);
      chk("pd_eng_val", eng_req_val, 1'b1);
      chk("pd_req_rdy", req_rdy, 2'b00);
      want[1] = 0;
      drive_req();
      #1;
      chk("pd_eng_val_drop", eng_req_val, 1'b0);
      step();
      #1;
      chk("pd_idle", busy, 1'b0);
      chk("pd_grant_held", grant_id, 1'b1);
      chk("pd_no_eng_hs", glog.size(), 0);
      want[0] = 1; want[1] = 1;
      drive_req();
      step();
      #1;
`ifdef HMAC_ARB_STRICT_PRIO_EN
      chk("pd_regrant", grant_id, 1'b0);
`else
      chk("pd_regrant", grant_id, 1'b1);
`endif
      eng_hold = 1'b0;
      drive_eng();
      wait_idle("pd_drain", 100);
      chk("pd_ngrants", glog.size(), 2);

      // Reset while waiting for a response
      rsp_rdy = 2'b00;
      want[1] = 1;
      drive_req();
      #1;
      n = 0;
      while (!rsp_val[1] && n < 20) begin
         step();
         #1;
         n++;
      end
      chk("mr_rsp_seen", rsp_val, 2'b10);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      #1;
      chk("mr_busy", busy, 1'b0);
      chk("mr_rsp_val", rsp_val, 2'b00);
      chk("mr_grant_id", grant_id, 1'b0);
      chk("mr_eng_val", eng_req_val, 1'b0);
      rsp_rdy = 2'b11;
      glog.delete();
      want[0] = 1;
      drive_req();
      wait_idle("mr_after_drain", 50);
      chk("mr_after_ngrants", glog.size(), 1);

      // NUM_REQ=3: move the pointer to 2, then check the wrap-around grant
      rv3 = 3'b010;
      step();
      #1;
      chk("r3_grant1", grant3, 2'd1);
      chk("r3_rdy1", rdy3, 3'b010);
      step();
      rv3 = 3'b011;
      #1;
      chk("r3_rsp_val", rspv3, 3'b010);
      chk("r3_rsp_hmac", rsp_hmac3, 128'hC0FF_EE00_1122_3344_5566_7788_99AA_BBCC);
      chk("r3_busy_rdy", rdy3, 3'b000);
      step();
      #1;
      chk("r3_idle", busy3, 1'b0);
      step();
      #1;
      chk("r3_wrap_grant", grant3, 2'd0);
      chk("r3_wrap_rdy", rdy3, 3'b001);
      step();
      rv3 = 3'b111;
      step();
      step();
      #1;
`ifdef HMAC_ARB_STRICT_PRIO_EN
      chk("r3_next_grant", grant3, 2'd0);
`else
      chk("r3_next_grant", grant3, 2'd1);
`endif
      rv3 = 3'b000;
      step();
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
